// File: rtl/alt_vipitc120_is2vid_mode_sequencer_pkg.sv
// ============================================================================
// Module  : alt_vipitc120_is2vid_mode_sequencer_pkg
// Purpose : Shared constants for the IS2Vid mode sequencer and mode-bank slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alt_vipitc120_is2vid_mode_sequencer_pkg;

    localparam int MODE_WORDS       = 20;
    localparam int FIELD_WORDS      = 19;
    localparam int MODE_STRIDE_LOG2 = 5;
    localparam int WORD_W           = 16;
    localparam int FLAG_W           = 2;

    localparam logic [2:0] ST_ENC_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENC_FETCH   = 3'd1;
    localparam logic [2:0] ST_ENC_SETTLE  = 3'd2;
    localparam logic [2:0] ST_ENC_WAIT_FB = 3'd3;
    localparam logic [2:0] ST_ENC_LOAD    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_ENC_IDLE,
        ST_FETCH   = ST_ENC_FETCH,
        ST_SETTLE  = ST_ENC_SETTLE,
        ST_WAIT_FB = ST_ENC_WAIT_FB,
        ST_LOAD    = ST_ENC_LOAD
    } seq_state_t;

    // Word offsets within one stored mode; the bank writer uses the same map.
    localparam logic [4:0] WIDX_FLAGS           = 5'd0;
    localparam logic [4:0] WIDX_SAMPLE_COUNT_F0 = 5'd1;
    localparam logic [4:0] WIDX_LINE_COUNT_F0   = 5'd2;
    localparam logic [4:0] WIDX_SAMPLE_COUNT_F1 = 5'd3;
    localparam logic [4:0] WIDX_LINE_COUNT_F1   = 5'd4;
    localparam logic [4:0] WIDX_H_FRONT_PORCH   = 5'd5;
    localparam logic [4:0] WIDX_H_SYNC_LENGTH   = 5'd6;
    localparam logic [4:0] WIDX_H_BLANK         = 5'd7;
    localparam logic [4:0] WIDX_V_FRONT_PORCH   = 5'd8;
    localparam logic [4:0] WIDX_V_SYNC_LENGTH   = 5'd9;
    localparam logic [4:0] WIDX_V_BLANK         = 5'd10;
    localparam logic [4:0] WIDX_V1_FRONT_PORCH  = 5'd11;
    localparam logic [4:0] WIDX_V1_SYNC_LENGTH  = 5'd12;
    localparam logic [4:0] WIDX_V1_BLANK        = 5'd13;
    localparam logic [4:0] WIDX_AP_LINE         = 5'd14;
    localparam logic [4:0] WIDX_V1_RISING_EDGE  = 5'd15;
    localparam logic [4:0] WIDX_F_RISING_EDGE   = 5'd16;
    localparam logic [4:0] WIDX_F_FALLING_EDGE  = 5'd17;
    localparam logic [4:0] WIDX_ANC_LINE        = 5'd18;
    localparam logic [4:0] WIDX_V1_ANC_LINE     = 5'd19;

endpackage

`default_nettype wire

// File: rtl/alt_vipitc120_is2vid_mode_shadow.sv
// ============================================================================
// Module  : alt_vipitc120_is2vid_mode_shadow
// Purpose : 20-word shadow register file holding the mode being prepared.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alt_vipitc120_is2vid_mode_shadow
    import alt_vipitc120_is2vid_mode_sequencer_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          we,
    input  logic [MODE_STRIDE_LOG2-1:0]   waddr,
    input  logic [WORD_W-1:0]             wdata,
    output logic [FLAG_W-1:0]             mode_flags,
    output logic [FIELD_WORDS*WORD_W-1:0] mode_fields
);

    logic [FLAG_W-1:0] r_flags;

    // Only the two defined flag bits of word 0 are kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= '0;
        end else if (we && (waddr == WIDX_FLAGS)) begin
            r_flags <= wdata[FLAG_W-1:0];
        end
    end

    assign mode_flags = r_flags;

    for (genvar gi = 0; gi < FIELD_WORDS; gi++) begin : g_field
        logic [WORD_W-1:0] r_word;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_word <= '0;
            end else if (we && (waddr == MODE_STRIDE_LOG2'(gi + 1))) begin
                r_word <= wdata;
            end
        end

        assign mode_fields[gi*WORD_W +: WORD_W] = r_word;
    end

endmodule

`default_nettype wire

// File: rtl/alt_vipitc120_is2vid_mode_sequencer.sv
// ============================================================================
// Module  : alt_vipitc120_is2vid_mode_sequencer
// Purpose : Fetches a stored video mode into shadow registers and strobes the
//           timing generator to load it on a frame boundary.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alt_vipitc120_is2vid_mode_sequencer
    import alt_vipitc120_is2vid_mode_sequencer_pkg::*;
#(
    parameter int MODE_W       = 3,
    parameter int CALC_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          mode_req,
    input  logic [MODE_W-1:0]             mode_req_idx,
    input  logic                          gen_running,
    input  logic                          frame_end,
    output logic                          bank_rd,
    output logic [MODE_W+4:0]             bank_addr,
    input  logic [WORD_W-1:0]             bank_rdata,
    output logic [FLAG_W-1:0]             mode_flags,
    output logic [FIELD_WORDS*WORD_W-1:0] mode_fields,
    output logic                          mode_load,
    output logic [MODE_W-1:0]             cur_mode_idx,
    output logic                          mode_valid,
    output logic                          busy
);

    localparam int                          c_settle_w   = $clog2(CALC_LATENCY + 1);
    localparam logic [MODE_STRIDE_LOG2-1:0] c_word_sat   = MODE_STRIDE_LOG2'(MODE_WORDS);
    localparam logic [c_settle_w-1:0]       c_settle_end = c_settle_w'(CALC_LATENCY - 1);

    seq_state_t                    r_state;
    seq_state_t                    w_state_nxt;
    logic                          w_start;
    logic                          w_bank_rd;
    logic [MODE_W+4:0]             w_bank_addr;
    logic                          w_mode_load;
    logic                          w_busy;

    logic [MODE_W-1:0]             r_tgt_idx;
    logic [MODE_W-1:0]             r_pend_idx;
    logic                          r_pend;
    logic [MODE_STRIDE_LOG2-1:0]   r_word_cnt;
    logic [c_settle_w-1:0]         r_settle_cnt;
    logic                          r_wr_en;
    logic [MODE_STRIDE_LOG2-1:0]   r_wr_word;
    logic [MODE_W-1:0]             r_cur_idx;
    logic                          r_mode_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bank_rd   = 1'b0;
        w_bank_addr = '0;
        w_mode_load = 1'b0;
        w_busy      = r_pend;

        case (r_state)
            ST_IDLE: begin
                if (mode_req || r_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_busy = 1'b1;
                // Counter parks at the saturation value on the cycle word 19 lands.
                if (r_word_cnt == c_word_sat) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_bank_rd   = 1'b1;
                    w_bank_addr = {r_tgt_idx, r_word_cnt};
                end
            end
            ST_SETTLE: begin
                w_busy = 1'b1;
                if (r_settle_cnt == c_settle_end) begin
                    w_state_nxt = ST_WAIT_FB;
                end
            end
            ST_WAIT_FB: begin
                w_busy = 1'b1;
                if (!gen_running || frame_end) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_busy      = 1'b1;
                w_mode_load = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tgt_idx    <= '0;
            r_pend_idx   <= '0;
            r_pend       <= 1'b0;
            r_word_cnt   <= '0;
            r_settle_cnt <= '0;
            r_wr_en      <= 1'b0;
            r_wr_word    <= '0;
            r_cur_idx    <= '0;
            r_mode_valid <= 1'b0;
        end else begin
            // A fresh request in IDLE overrides any stored one.
            if (w_start) begin
                r_tgt_idx <= mode_req ? mode_req_idx : r_pend_idx;
            end

            if (r_state == ST_IDLE) begin
                r_pend <= 1'b0;
            end else if (mode_req) begin
                r_pend     <= 1'b1;
                r_pend_idx <= mode_req_idx;
            end

            if (r_state == ST_FETCH) begin
                if (r_word_cnt != c_word_sat) begin
                    r_word_cnt <= r_word_cnt + MODE_STRIDE_LOG2'(1);
                end
            end else begin
                r_word_cnt <= '0;
            end

            if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + c_settle_w'(1);
            end else begin
                r_settle_cnt <= '0;
            end

            r_wr_en   <= w_bank_rd;
            r_wr_word <= r_word_cnt;

            if (r_state == ST_LOAD) begin
                r_cur_idx    <= r_tgt_idx;
                r_mode_valid <= 1'b1;
            end
        end
    end

    alt_vipitc120_is2vid_mode_shadow u_shadow (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (r_wr_en),
        .waddr       (r_wr_word),
        .wdata       (bank_rdata),
        .mode_flags  (mode_flags),
        .mode_fields (mode_fields)
    );

    assign bank_rd      = w_bank_rd;
    assign bank_addr    = w_bank_addr;
    assign mode_load    = w_mode_load;
    assign busy         = w_busy;
    assign cur_mode_idx = r_cur_idx;
    assign mode_valid   = r_mode_valid;

endmodule

`default_nettype wire

// File: tb/tb_alt_vipitc120_is2vid_mode_sequencer.sv
// ============================================================================
// Module  : tb_alt_vipitc120_is2vid_mode_sequencer
// Purpose : Scoreboard bench for the IS2Vid mode sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alt_vipitc120_is2vid_mode_sequencer;

    localparam int MODE_W       = 3;
    localparam int CALC_LATENCY = 1;
    // Edges from request acceptance to the first WAIT_FB sample.
    localparam int WAIT_OFS     = 21 + CALC_LATENCY + 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mode_req;
    logic [2:0]   mode_req_idx;
    logic         gen_running;
    logic         frame_end;
    logic         bank_rd;
    logic [7:0]   bank_addr;
    logic [15:0]  bank_rdata;
    logic [1:0]   mode_flags;
    logic [303:0] mode_fields;
    logic         mode_load;
    logic [2:0]   cur_mode_idx;
    logic         mode_valid;
    logic         busy;

    always #5 clk = ~clk;

    alt_vipitc120_is2vid_mode_sequencer #(
        .MODE_W       (MODE_W),
        .CALC_LATENCY (CALC_LATENCY)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode_req     (mode_req),
        .mode_req_idx (mode_req_idx),
        .gen_running  (gen_running),
        .frame_end    (frame_end),
        .bank_rd      (bank_rd),
        .bank_addr    (bank_addr),
        .bank_rdata   (bank_rdata),
        .mode_flags   (mode_flags),
        .mode_fields  (mode_fields),
        .mode_load    (mode_load),
        .cur_mode_idx (cur_mode_idx),
        .mode_valid   (mode_valid),
        .busy         (busy)
    );

    logic [15:0] mem [8][20];

    function automatic logic [15:0] mem_rd(input logic [7:0] a);
        int w;
        w = int'(a[4:0]);
        if (w < 20) return mem[a[7:5]][w];
        return 16'hdead;
    endfunction

    always @(posedge clk) bank_rdata <= bank_rd ? mem_rd(bank_addr) : 16'hbeef;

    function automatic logic [303:0] exp_fields(input logic [2:0] idx);
        logic [303:0] r;
        r = '0;
        for (int w = 1; w < 20; w++) r[(w-1)*16 +: 16] = mem[idx][w];
        return r;
    endfunction

    function automatic int edge_now();
        return int'(($time - 5) / 10);
    endfunction

    int tests = 0;
    int fails = 0;
    int n_loads = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_wide(input string name, input logic [303:0] act, input logic [303:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: timeline of request/load edges -------
    typedef struct {
        logic [2:0] idx;
        int         edge_n;
    } load_t;
    load_t sb[$];

    bit         m_active, m_pend, m_valid;
    int         m_start, m_load_edge;
    logic [2:0] m_idx, m_pidx, m_cur;
    bit         exp_rd, exp_busy;
    logic [7:0] exp_addr;

    task automatic model_clear();
        m_active = 0; m_pend = 0; m_valid = 0;
        m_start = 0; m_load_edge = -1;
        m_idx = 0; m_pidx = 0; m_cur = 0;
        exp_rd = 0; exp_busy = 0; exp_addr = 0;
        sb.delete();
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_clear();
            end else begin
                int x;
                x = edge_now();
                if (m_active) begin
                    if (mode_req) begin
                        m_pend = 1; m_pidx = mode_req_idx;
                    end
                    if (m_load_edge < 0) begin
                        if (x >= m_start + WAIT_OFS && (!gen_running || frame_end)) begin
                            m_load_edge = x;
                            sb.push_back('{idx: m_idx, edge_n: x});
                        end
                    end else if (x == m_load_edge + 1) begin
                        m_active = 0; m_cur = m_idx; m_valid = 1;
                    end
                end else if (mode_req || m_pend) begin
                    m_active = 1; m_start = x; m_load_edge = -1;
                    m_idx = mode_req ? mode_req_idx : m_pidx;
                    m_pend = 0;
                end
                exp_busy = m_active || m_pend;
                exp_rd   = m_active && (m_load_edge < 0) && ((x - m_start) <= 19);
                exp_addr = exp_rd ? {m_idx, 5'(x - m_start)} : 8'h00;
            end
        end
    end

    // ---------------- monitor -------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            check("busy", busy, exp_busy);
            check("bank_rd", bank_rd, exp_rd);
            if (exp_rd) check("bank_addr", bank_addr, exp_addr);
            check("cur_mode_idx", cur_mode_idx, m_cur);
            check("mode_valid", mode_valid, m_valid);
            if (mode_load) begin
                n_loads++;
                if (sb.size() == 0) begin
                    check("unexpected_load", 1, 0);
                end else begin
                    load_t e;
                    e = sb.pop_front();
                    check("load_edge", edge_now(), e.edge_n);
                    check("load_flags", mode_flags, mem[e.idx][0][1:0]);
                    check_wide("load_fields", mode_fields, exp_fields(e.idx));
                end
            end
        end
    end

    // ---------------- stimulus ------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] idx);
        mode_req = 1; mode_req_idx = idx;
        tick();
        mode_req = 0;
    endtask

    task automatic wait_load(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (mode_load) break;
        end
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bank_rd"}, bank_rd, 0);
        check({tag, "_bank_addr"}, bank_addr, 0);
        check({tag, "_mode_load"}, mode_load, 0);
        check({tag, "_cur"}, cur_mode_idx, 0);
        check({tag, "_valid"}, mode_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_flags"}, mode_flags, 0);
        check_wide({tag, "_fields"}, mode_fields, '0);
    endtask

    initial begin
        int n, l0;
        reset_n = 0; mode_req = 0; mode_req_idx = 0; gen_running = 0; frame_end = 0;
        for (int m = 0; m < 8; m++)
            for (int w = 0; w < 20; w++)
                mem[m][w] = (m == 3) ? 16'h0300 + 16'(w) : 16'($urandom);

        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1;
        tick();

        // Basic fetch of mode 3 with the generator stopped.
        request(3'd3);
        wait_load(60, n);
        check("t1_latency", n, 23);
        check("t1_field0", mode_fields[15:0], 16'h0301);
        check("t1_flags", mode_flags, 2'b00);
        wait_idle(50);

        // Early frame_end is ignored; the later one triggers the load.
        gen_running = 1;
        l0 = n_loads;
        request(3'(($urandom % 8)));
        repeat (5) tick();
        frame_end = 1; tick(); frame_end = 0;
        repeat (99) tick();
        check("t2_no_early_load", n_loads - l0, 0);
        frame_end = 1; tick(); frame_end = 0;
        check("t2_load_after_fe", mode_load, 1);
        wait_idle(50);
        check("t2_one_load", n_loads - l0, 1);
        gen_running = 0;

        // Last pending request wins.
        l0 = n_loads;
        request(3'd4);
        repeat (2) tick();
        request(3'd1);
        repeat (3) tick();
        request(3'd5);
        tick();
        request(3'd2);
        wait_idle(200);
        check("t3_loads", n_loads - l0, 2);
        check("t3_cur", cur_mode_idx, 3'd2);

        // Reset while fetching word 10.
        l0 = n_loads;
        request(3'd5);
        n = 0;
        while (!(bank_rd && bank_addr[4:0] == 5'd10) && n < 40) begin
            tick();
            n++;
        end
        check("t4_reached_w10", bank_addr, 8'hAA);
        reset_n = 0;
        #1;
        check_all_zero("t4_midrst");
        repeat (2) tick();
        reset_n = 1;
        tick();
        check("t4_no_load", n_loads - l0, 0);
        request(3'd2);
        wait_idle(100);
        check("t4_fresh_load", n_loads - l0, 1);
        check("t4_cur", cur_mode_idx, 3'd2);

        // Request coincident with LOAD becomes pending.
        l0 = n_loads;
        request(3'd6);
        wait_load(60, n);
        check("t5_load6", mode_load, 1);
        request(3'd7);
        check("t5_busy", busy, 1);
        wait_idle(100);
        check("t5_loads", n_loads - l0, 2);
        check("t5_cur", cur_mode_idx, 3'd7);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            mode_req     = ($urandom % 16) == 0;
            mode_req_idx = 3'($urandom % 8);
            if (($urandom % 200) == 0) gen_running = ~gen_running;
            frame_end    = ($urandom % 40) == 0;
            tick();
        end
        mode_req = 0; frame_end = 0; gen_running = 0;
        tick();
        wait_idle(300);
        repeat (3) tick();
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
